line_memory_responder: RTL and testbench
========================================

LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 10, meaning the number of cycles from request acceptance to ack (legal range 1..255).
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning the number of 256-bit lines stored (power of two).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_enable_i, input, 1 bit: request valid, held by the initiator until ack.
REQ-006 The block SHALL have port mem_write_i, input, 1 bit: 1 = write line, 0 = read line.
REQ-007 The block SHALL have port mem_addr_i, input, 32 bits: byte address of the line.
REQ-008 The block SHALL have port mem_data_i, input, 256 bits: write line data.
REQ-009 The block SHALL have port mem_ack_o, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port mem_data_o, output, 256 bits: read line data, valid while mem_ack_o=1 for reads.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY, ACK.
REQ-012 In IDLE, mem_enable_i=1 at a rising edge SHALL accept the request: latch write, address and data; load the counter with LATENCY-1; go to BUSY (go directly to ACK when LATENCY=1).
REQ-013 In BUSY, the counter SHALL decrement each cycle; on the edge where it reads 0, the FSM SHALL go to ACK.
REQ-014 The block SHALL ignore mem_enable_i, mem_write_i, mem_addr_i and mem_data_i while in BUSY or ACK; only the latched copies are used.
REQ-015 For a request accepted at edge T0, mem_ack_o SHALL be 1 for exactly the cycle between edges T0+LATENCY and T0+LATENCY+1, and 0 at all other times.
REQ-016 A latched write SHALL commit to the line array at edge T0+LATENCY, and no earlier.
REQ-017 A latched read SHALL load mem_data_o from the line array at edge T0+LATENCY.
REQ-018 mem_data_o SHALL hold its value until the next read completes; write completions SHALL leave mem_data_o unchanged.
REQ-019 ACK SHALL always return to IDLE; mem_enable_i in the ACK cycle SHALL NOT be accepted.
REQ-020 Back-to-back requests SHALL be accepted no sooner than the edge after the ack cycle (minimum spacing LATENCY+1 cycles).
REQ-021 The line index SHALL be mem_addr_i[5 +: log2(DEPTH)]; bits [4:0] and the upper bits SHALL be ignored, so addresses wrap modulo DEPTH lines.
REQ-022 A read of a line written by the immediately preceding request SHALL return the new data.

Reset
REQ-023 While rst_i=0: FSM=IDLE, counter=0, mem_ack_o=0, mem_data_o=0, latched request cleared.
REQ-024 Reset SHALL abort any request in BUSY or ACK without committing it: no array write and no ack pulse.
REQ-025 Line array contents SHALL NOT be cleared by reset; initialisation is the bench's responsibility.
REQ-026 The first request SHALL be accepted no earlier than the first rising edge after rst_i deasserts.

Structure
REQ-027 The shared package mem_if_pkg SHALL hold LINE_W=256, ADDR_W=32, OFFSET_W=5, and the FSM state enum.
REQ-028 The storage SHALL be one sub-module, line_ram: DEPTH x LINE_W, with synchronous write and registered read, driven by the FSM's commit and read strobes.

Verification
REQ-029 Reset, then write addr 0x0000_0040 data {8{32'hDEADBEEF}} -> ack exactly 10 cycles after acceptance, one cycle wide; mem_data_o stays 0.
REQ-030 Read addr 0x0000_0040 -> at ack, mem_data_o={8{32'hDEADBEEF}}; addr 0x0000_005F returns the same line (offset ignored).
REQ-031 Write addr 0x0000_8040 with DEPTH=512 -> overwrites line 2 (wrap); a subsequent read of 0x40 returns the new data.
REQ-032 Change addr and data mid-BUSY, and hold enable through the ack cycle -> the original latched request completes; the next acceptance occurs on the edge after ack.
REQ-033 Assert rst_i=0 at cycle 5 of a write -> no ack; the line is unchanged on re-read; mem_data_o=0.
REQ-034 Run with LATENCY=1 -> ack on the cycle immediately after acceptance; back-to-back write-then-read of the same line returns the written data.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared widths, FSM encoding and request payload for the line memory responder.
package mem_if_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned CNT_W    = 8;

  // Legacy-compatible state encodings, wrapped by the enum below.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    BUSY = S_BUSY,
    ACK  = S_ACK
  } state_e;

  // Request fields captured at acceptance (line index is held separately,
  // its width depends on DEPTH).
  typedef struct packed {
    logic              write;
    logic [LINE_W-1:0] data;
  } req_t;

endpackage

// File: rtl/line_ram.sv
// DEPTH x LINE_W line store: synchronous write, registered read.
module line_ram
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Array write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: holds the last read line until the next read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/line_memory_responder.sv
// Fixed-latency line memory responder: accepts one request at a time and
// completes it with a one-cycle ack LATENCY cycles after acceptance.
module line_memory_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic [LINE_W-1:0] mem_data_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  req_t               lat_req, lat_req_n;
  logic [IDX_W-1:0]   lat_idx, lat_idx_n;
  logic               ack_n;
  logic               commit_c;
  logic               read_c;

  // Offset bits and address bits above the line index are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[ADDR_W-1:OFFSET_W+IDX_W], mem_addr_i[OFFSET_W-1:0]};

  // State, counter, latched request and ack registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_req   <= '0;
      lat_idx   <= '0;
      mem_ack_o <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lat_req   <= lat_req_n;
      lat_idx   <= lat_idx_n;
      mem_ack_o <= ack_n;
    end
  end

  // Next-state logic. ACK is the final cycle of a request: the edge leaving
  // it commits/reads the array and raises mem_ack_o, so the ack pulse lands
  // LATENCY edges after acceptance while the FSM is already back in IDLE.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lat_req_n = lat_req;
    lat_idx_n = lat_idx;
    ack_n     = 1'b0;
    commit_c  = 1'b0;
    read_c    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_enable_i) begin
          lat_req_n.write = mem_write_i;
          lat_req_n.data  = mem_data_i;
          lat_idx_n       = mem_addr_i[OFFSET_W +: IDX_W];
          cnt_n           = CNT_W'(LATENCY - 1);
          state_n         = (LATENCY == 1) ? ACK : BUSY;
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = ACK;
        end
      end
      ACK: begin
        state_n  = IDLE;
        ack_n    = 1'b1;
        commit_c = lat_req.write;
        read_c   = ~lat_req.write;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  line_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_line_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (commit_c),
    .re    (read_c),
    .addr  (lat_idx),
    .wdata (lat_req.data),
    .rdata (mem_data_o)
  );

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: LATENCY=10 and LATENCY=1 instances.
module tb_line_memory_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic         en0 = 1'b0, wr0 = 1'b0;
  logic [31:0]  addr0 = '0;
  logic [255:0] data0 = '0;
  logic         ack0;
  logic [255:0] q0;

  logic         en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] data1 = '0;
  logic         ack1;
  logic [255:0] q1;

  int checks = 0;
  int errors = 0;

  logic [255:0] dead, a5, p1, qq, zz, xx, zero;

  always #5 clk = ~clk;

  line_memory_responder #(.LATENCY(10), .DEPTH(512)) dut (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en0), .mem_write_i(wr0),
    .mem_addr_i(addr0), .mem_data_i(data0), .mem_ack_o(ack0), .mem_data_o(q0)
  );

  line_memory_responder #(.LATENCY(1), .DEPTH(512)) dut1 (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en1), .mem_write_i(wr1),
    .mem_addr_i(addr1), .mem_data_i(data1), .mem_ack_o(ack1), .mem_data_o(q1)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Count edges until ack0 is seen (bounded); called right after an accept edge.
  task automatic wait_ack0(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (ack0) break;
    end
  endtask

  // One full request on the LATENCY=10 instance, checking latency and pulse width.
  task automatic txn0(input string tag, input logic wr, input logic [31:0] a,
                      input logic [255:0] d, output logic [255:0] q);
    int n;
    en0 = 1'b1; wr0 = wr; addr0 = a; data0 = d;
    @(posedge clk);
    wait_ack0(n);
    q = q0;
    en0 = 1'b0;
    check({tag, "_lat"}, 256'(n), 256'(10));
    @(posedge clk);
    #1;
    check({tag, "_ack_width"}, 256'(ack0), 256'(0));
  endtask

  initial begin
    logic [255:0] q;
    int n;
    int hits;
    dead = {8{32'hDEADBEEF}};
    a5   = {8{32'hA5A5_0102}};
    p1   = {8{32'h1234_5678}};
    qq   = {8{32'h0BAD_F00D}};
    zz   = {8{32'hFFFF_0000}};
    xx   = {8{32'hC0FF_EE11}};
    zero = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack0", 256'(ack0), 256'(0));
    check("rst_q0", q0, zero);
    check("rst_ack1", 256'(ack1), 256'(0));
    check("rst_q1", q1, zero);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Write 0x40; data output must stay 0
    txn0("wr40", 1'b1, 32'h0000_0040, dead, q);
    check("wr40_q", q, zero);

    // Read back, then via an address with a non-zero offset
    txn0("rd40", 1'b0, 32'h0000_0040, zero, q);
    check("rd40_q", q, dead);
    txn0("rd5f", 1'b0, 32'h0000_005F, zero, q);
    check("rd5f_q", q, dead);

    // Wrapping address overwrites line 2; write leaves mem_data_o alone
    txn0("wr8040", 1'b1, 32'h0000_8040, a5, q);
    check("wr8040_q_held", q, dead);
    txn0("rd40b", 1'b0, 32'h0000_0040, zero, q);
    check("rd40b_q", q, a5);

    // Inputs changed mid-BUSY, enable held through the ack cycle
    en0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0000_0080; data0 = p1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    wr0 = 1'b0; addr0 = 32'h0000_0040; data0 = qq;
    wait_ack0(n);
    check("hold_lat1", 256'(n), 256'(7));
    wait_ack0(n);
    check("hold_lat2", 256'(n), 256'(11));
    check("hold_rd40_q", q0, a5);
    en0 = 1'b0;
    @(posedge clk);
    #1;
    check("hold_ack_width", 256'(ack0), 256'(0));
    txn0("rd80", 1'b0, 32'h0000_0080, zero, q);
    check("rd80_q", q, p1);

    // Reset in the middle of a write aborts it
    en0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0000_0040; data0 = zz;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    en0 = 1'b0;
    @(posedge clk);
    #1;
    check("abort_rst_ack", 256'(ack0), 256'(0));
    check("abort_rst_q", q0, zero);
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (ack0) hits++;
    end
    check("abort_no_ack", 256'(hits), 256'(0));
    txn0("abort_rd40", 1'b0, 32'h0000_0040, zero, q);
    check("abort_rd40_q", q, a5);

    // LATENCY=1: back-to-back write then read of line 1
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0020; data1 = xx;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("l1_wr_ack", 256'(ack1), 256'(1));
    wr1 = 1'b0;
    @(posedge clk);
    #1;
    check("l1_gap_ack", 256'(ack1), 256'(0));
    @(posedge clk);
    #1;
    check("l1_rd_ack", 256'(ack1), 256'(1));
    check("l1_rd_q", q1, xx);
    en1 = 1'b0;
    @(posedge clk);
    #1;
    check("l1_ack_width", 256'(ack1), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
